// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 8;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Largest counter / ratio value for a given width.
  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered ratio, update/done handshake and compare.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_boundary,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_ratio,
  input  logic             i_update,
  output logic             o_done,
  output logic             o_signal
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(pwm_max(WIDTH));

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_target;
  logic             r_pending;
  logic             r_done;
  logic             r_signal;
  logic             w_active;

  // Full-scale target forces high so there is no dropout at cnt==MAX.
  always_comb begin
    w_active = 1'b0;
    if (r_target == MAX) begin
      w_active = 1'b1;
    end else begin
      w_active = (i_cnt < r_target);
    end
  end

  // Shadow capture, promotion to target at the period boundary, done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= '0;
      r_target  <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_update) begin
        r_shadow <= i_ratio;
      end
      if (i_boundary && i_update) begin
        // Same-cycle request bypasses the shadow and goes live immediately.
        r_target  <= i_ratio;
        r_pending <= 1'b0;
        r_done    <= 1'b1;
      end else if (i_boundary && r_pending) begin
        r_target  <= r_shadow;
        r_pending <= 1'b0;
        r_done    <= 1'b1;
      end else if (i_update) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered, gated compare output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_signal <= 1'b0;
    end else begin
      r_signal <= i_enable & w_active;
    end
  end

  assign o_done   = r_done;
  assign o_signal = r_signal;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler/counter timebase feeding NUM_CH channels.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [PRESCALE_W-1:0]   prescale,
  input  logic                    center_mode,
  input  logic [NUM_CH-1:0]       pwm_enable,
  input  logic [NUM_CH*WIDTH-1:0] pwm_ratio,
  input  logic [NUM_CH-1:0]       pwm_update,
  output logic [NUM_CH-1:0]       pwm_done,
  output logic                    period_start,
  output logic [NUM_CH-1:0]       pwm_signal
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(pwm_max(WIDTH));

  logic [PRESCALE_W-1:0] r_pcnt;
  logic [WIDTH-1:0]      r_cnt;
  dir_t                  r_dir;
  mode_t                 r_mode;
  logic                  r_period_start;

  logic                  w_tick;
  logic                  w_bound;
  mode_t                 w_mode_eff;
  logic [WIDTH-1:0]      w_cnt_nxt;
  dir_t                  w_dir_nxt;

  assign w_tick  = (r_pcnt >= prescale);
  assign w_bound = w_tick && (r_cnt == '0) && (r_dir == DIR_UP);

  // Prescaler: unsigned compare so a lowered prescale ticks at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRESCALE_W'(1);
    end
  end

  // Next counter value and direction; a mode latched at the boundary applies to that step.
  always_comb begin
    w_mode_eff = w_bound ? mode_t'(center_mode) : r_mode;
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    if (w_mode_eff == MODE_EDGE) begin
      w_dir_nxt = DIR_UP;
      if (r_cnt == MAX) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end else if (r_dir == DIR_UP) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
      w_dir_nxt = (w_cnt_nxt == MAX) ? DIR_DOWN : DIR_UP;
    end else begin
      w_cnt_nxt = r_cnt - WIDTH'(1);
      w_dir_nxt = (w_cnt_nxt == '0) ? DIR_UP : DIR_DOWN;
    end
  end

  // Timebase state: counter, direction and mode advance only on tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_dir  <= DIR_UP;
      r_mode <= MODE_EDGE;
    end else if (w_tick) begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
      if (w_bound) begin
        r_mode <= mode_t'(center_mode);
      end
    end
  end

  // Period-start pulse, one cycle after the boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_bound;
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_boundary(w_bound),
      .i_cnt     (r_cnt),
      .i_enable  (pwm_enable[g]),
      .i_ratio   (pwm_ratio[g*WIDTH +: WIDTH]),
      .i_update  (pwm_update[g]),
      .o_done    (pwm_done[g]),
      .o_signal  (pwm_signal[g])
    );
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator. It is the successor to the single-channel 8-bit PWM. All channels share one timebase, built from a programmable prescaler and a WIDTH-bit counter. Each channel has double-buffered duty ratios, an update/done handshake, edge- or centre-aligned mode, and true 0 %/100 % duty. It sits between the motor/servo control registers and the pad drivers.

Parameters:
NUM_CH, 4, number of PWM channels
WIDTH, 8, counter/ratio width; MAX = 2^WIDTH-1
PRESCALE_W, 8, prescaler width

Ports:
clock  input  1  main clock
reset_n  input  1  asynchronous active-low reset
prescale  input  PRESCALE_W  timebase advances every prescale+1 clocks
center_mode  input  1  0 = edge-aligned, 1 = centre-aligned (sampled at period boundary)
pwm_enable  input  NUM_CH  per-channel output enable
pwm_ratio  input  NUM_CH*WIDTH  per-channel duty ratio; channel i = bits [i*WIDTH +: WIDTH]
pwm_update  input  NUM_CH  per-channel single-cycle request to capture pwm_ratio
pwm_done  output  NUM_CH  one-cycle pulse when the new ratio becomes active
period_start  output  1  one-cycle pulse at each period boundary
pwm_signal  output  NUM_CH  registered PWM outputs

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous, active-low.
- Reset values:
  - prescaler count, counter, direction (up), all shadow and target registers: 0.
  - pending flags, pwm_done, period_start, pwm_signal: 0.
  - latched mode: edge-aligned.
- Prescaler:
  - pcnt increments every clock.
  - tick = (pcnt >= prescale). On tick, pcnt returns to 0.
  - Lowering prescale below the current pcnt produces a tick on the next compare, with no long wrap.
  - prescale = 0 gives a tick every clock.
- Counter advances only on tick.
  - Edge mode: 0,1,…,MAX,0,… (period MAX+1 ticks).
  - Centre mode: 0,1,…,MAX,MAX-1,…,1,0,… (period 2*MAX ticks). Direction flips to down on reaching MAX and to up on reaching 0.
- Period boundary = tick && cnt==0 && dir==up.
  - center_mode is latched only at a boundary.
  - On a mode change, the counter continues from 0 going up.
- Per channel, double buffering:
  - pwm_update=1 captures pwm_ratio into shadow and sets pending.
  - A repeated update while pending overwrites shadow. Only one done is produced.
  - At a boundary with pending set: target <= shadow, pending cleared, pwm_done pulses high in the next cycle for exactly 1 cycle.
  - Update in the same cycle as a boundary: pwm_ratio is loaded into target directly, and pwm_done pulses the next cycle.
- Compare, registered (1-cycle latency):
  - pwm_signal <= pwm_enable & (target==MAX ? 1 : cnt < target).
  - target = 0 gives a constant low output.
  - target = MAX gives a constant high output, with no glitch at cnt==MAX.
- pwm_enable deassert: the output goes low on the next clock. Counter, shadow and handshake keep running.
- period_start is registered and pulses 1 cycle after each boundary.
- Reset asserted mid-period: all state clears immediately. Any pending update is lost and no done is issued.
- Arithmetic:
  - Counter is WIDTH bits with no overflow; wrap is explicit.
  - The prescaler compare is unsigned.

Decomposition:
- Package pwm_pkg holds:
  - mode encoding constants (MODE_EDGE = 0, MODE_CENTER = 1);
  - default WIDTH, NUM_CH and PRESCALE_W;
  - a function returning MAX for a given WIDTH.
- Submodule pwm_channel: shadow, pending, target, done and compare for one channel. It is instantiated NUM_CH times by a generate loop.
- The top level holds the prescaler, counter, direction, mode latch and period_start.

Test Plan:
1. Reset mid-run, then release, prescale=0, edge mode, ch0 update ratio=64 → pwm_done[0] one pulse after first boundary; pwm_signal[0] high 64 of every 256 clocks.
2. prescale=3, ch1 ratio=128 → counter steps every 4 clocks; period_start spaced 1024 clocks; high time 512 clocks.
3. Ratio 0 and ratio 255 (WIDTH=8) on ch2/ch3 → constant 0 and constant 1 for ≥3 periods, no single-cycle glitch.
4. center_mode=1, ratio=100 → period 510 ticks; high 199 ticks, low 311, centred on cnt==0; mode switches only at boundary.
5. Three updates to ch0 (10, 20, 30) within one period, plus a same-cycle update+boundary on ch1 → ch0 target=30 with a single done; ch1 new ratio active that period.
6. Toggle pwm_enable[1] low for 5 clocks mid-period → output low from next clock; counter unaffected; resumes correct duty on re-enable.
